// File: rtl/preg_pkg.sv
// Shared defaults and slot record for the elastic pipeline-stage register.
package preg_pkg;

    localparam int PREG_DATA_W_DEF = 64;
    localparam int PREG_CTRL_W_DEF = 16;
    localparam int PREG_CNT_W_DEF  = 16;

    typedef struct packed {
        logic                       valid;
        logic [PREG_CTRL_W_DEF-1:0] ctrl;
        logic [PREG_DATA_W_DEF-1:0] data;
    } preg_slot_t;

endpackage

// File: rtl/preg_slot.sv
// One valid+ctrl+data holding register; clear wins over load, and clear zeroes
// the payload only when FLUSH_CLEAR_DATA is set.
module preg_slot import preg_pkg::*; #(
    parameter int DATA_WIDTH       = PREG_DATA_W_DEF,
    parameter int CTRL_WIDTH       = PREG_CTRL_W_DEF,
    parameter bit FLUSH_CLEAR_DATA = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  valid_q, valid_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (i_clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (FLUSH_CLEAR_DATA) begin
                data_d = '0;
            end
        end else if (i_load) begin
            valid_d = 1'b1;
            ctrl_d  = i_ctrl;
            data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_ctrl  = ctrl_q;
    assign o_data  = data_q;

endmodule

// File: rtl/preg_stage_elastic.sv
// Handshaked pipeline-stage register with stall hold, flush-to-bubble and a
// saturating stall counter. Define PREG_SKID_EN for a second (skid) slot and a registered o_ready.
module preg_stage_elastic import preg_pkg::*; #(
    parameter int DATA_WIDTH       = PREG_DATA_W_DEF,
    parameter int CTRL_WIDTH       = PREG_CTRL_W_DEF,
    parameter bit FLUSH_CLEAR_DATA = 1'b1,
    parameter int CNT_WIDTH        = PREG_CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_flush,
    input  logic                  i_stall,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    logic                  main_valid;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [DATA_WIDTH-1:0] main_data;
    logic                  main_load, main_clear;
    logic [CTRL_WIDTH-1:0] main_ctrl_in;
    logic [DATA_WIDTH-1:0] main_data_in;
    logic                  accept, release_out;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    assign release_out = main_valid & i_ready & ~i_stall;
    assign accept      = i_valid & o_ready & ~i_flush;

`ifdef PREG_SKID_EN
    logic                  skid_valid, skid_load, skid_clear;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    // While the skid is full o_ready is low, so a skid-to-main move never races an accept.
    always_comb begin
        main_load    = (accept & (~main_valid | (release_out & ~skid_valid)))
                     | (release_out & skid_valid);
        main_clear   = i_flush | (release_out & ~skid_valid & ~accept);
        main_ctrl_in = skid_valid ? skid_ctrl : i_ctrl;
        main_data_in = skid_valid ? skid_data : i_data;
        skid_load    = accept & main_valid & ~release_out;
        skid_clear   = i_flush | (release_out & skid_valid);
    end

    preg_slot #(
        .DATA_WIDTH       (DATA_WIDTH),
        .CTRL_WIDTH       (CTRL_WIDTH),
        .FLUSH_CLEAR_DATA (FLUSH_CLEAR_DATA)
    ) u_skid (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_load   (skid_load),
        .i_clear  (skid_clear),
        .i_ctrl   (i_ctrl),
        .i_data   (i_data),
        .o_valid  (skid_valid),
        .o_ctrl   (skid_ctrl),
        .o_data   (skid_data)
    );

    assign o_ready = ~skid_valid;
`else
    always_comb begin
        main_load    = accept;
        main_clear   = i_flush | (release_out & ~accept);
        main_ctrl_in = i_ctrl;
        main_data_in = i_data;
    end

    assign o_ready = ~main_valid | (i_ready & ~i_stall);
`endif

    preg_slot #(
        .DATA_WIDTH       (DATA_WIDTH),
        .CTRL_WIDTH       (CTRL_WIDTH),
        .FLUSH_CLEAR_DATA (FLUSH_CLEAR_DATA)
    ) u_main (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_load   (main_load),
        .i_clear  (main_clear),
        .i_ctrl   (main_ctrl_in),
        .i_data   (main_data_in),
        .o_valid  (main_valid),
        .o_ctrl   (main_ctrl),
        .o_data   (main_data)
    );

    // Counts cycles an entry sits on the output unconsumed; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !release_out && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_valid     = main_valid;
    assign o_ctrl      = main_ctrl;
    assign o_data      = main_data;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_preg_stage_elastic.sv
// Bench for preg_stage_elastic: queue-based reference model plus directed scenarios.
module tb_preg_stage_elastic;

    localparam int DW      = 64;
    localparam int CW      = 16;
    localparam int NW      = 4;
    localparam bit FCD     = 1'b1;
    localparam int CNT_MAX = (1 << NW) - 1;

    logic          i_clk    = 1'b0;
    logic          i_arst_n = 1'b1;
    logic          i_flush  = 1'b0;
    logic          i_stall  = 1'b0;
    logic          i_valid  = 1'b0;
    logic          i_ready  = 1'b0;
    logic [CW-1:0] i_ctrl   = '0;
    logic [DW-1:0] i_data   = '0;
    logic          o_ready, o_valid;
    logic [CW-1:0] o_ctrl;
    logic [DW-1:0] o_data;
    logic [NW-1:0] o_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    int            m_cnt  = 0;
    logic [DW-1:0] m_last = '0;
    bit            armed  = 1'b0;
    bit            seen_c = 1'b0;

    preg_stage_elastic #(
        .DATA_WIDTH       (DW),
        .CTRL_WIDTH       (CW),
        .FLUSH_CLEAR_DATA (FCD),
        .CNT_WIDTH        (NW)
    ) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_flush     (i_flush),
        .i_stall     (i_stall),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_ctrl      (i_ctrl),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_ctrl      (o_ctrl),
        .o_data      (o_data),
        .o_stall_cnt (o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Capacity 2 with the skid slot (ready = not full); capacity 1 otherwise,
    // where a full stage can still take an entry in the cycle it drains.
    function automatic bit m_ready();
`ifdef PREG_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || (i_ready && !i_stall);
`endif
    endfunction

    always @(posedge i_clk or negedge i_arst_n) begin
        bit rel, acc;
        if (!i_arst_n) begin
            mq.delete();
            m_cnt  = 0;
            m_last = '0;
        end else begin
            rel = (mq.size() > 0) && i_ready && !i_stall;
            acc = i_valid && m_ready() && !i_flush;
            if ((mq.size() > 0) && !rel && (m_cnt < CNT_MAX)) m_cnt++;
            if (i_flush) begin
                if (mq.size() > 0) m_last = mq[0].d;
                mq.delete();
            end else begin
                if (rel) begin
                    m_last = mq[0].d;
                    void'(mq.pop_front());
                end
                if (acc) mq.push_back('{c: i_ctrl, d: i_data});
            end
        end
    end

    always @(negedge i_clk) begin
        if (armed && i_arst_n) begin
            chk("m_valid", o_valid, (mq.size() > 0));
            chk("m_ctrl", o_ctrl, (mq.size() > 0) ? mq[0].c : '0);
            chk("m_data", o_data, (mq.size() > 0) ? mq[0].d : (FCD ? '0 : m_last));
            chk("m_ready", o_ready, m_ready());
            chk("m_cnt", o_stall_cnt, m_cnt);
            if (o_valid && o_data == 64'hC) seen_c = 1'b1;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_clk);
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        i_valid = v;
        i_data  = d;
        i_ctrl  = d[15:0] ^ 16'h5A5A;
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #3;
        i_arst_n = 1'b0;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ctrl", o_ctrl, 0);
        chk("rst_data", o_data, 0);
        chk("rst_cnt", o_stall_cnt, 0);
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_ready = 1'b0;
        drive(1'b0, 64'h0);
        @(negedge i_clk);
        #1;
        i_arst_n = 1'b1;
        armed    = 1'b1;
        at_neg();
        chk("rst_ready", o_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // streaming
        step(); drive(1'b1, 64'h10); i_ready = 1'b1;
        step(); drive(1'b1, 64'h11); at_neg(); chk("stream_0x10", o_data, 64'h10);
        step(); drive(1'b1, 64'h12); at_neg(); chk("stream_0x11", o_data, 64'h11);
        step(); drive(1'b0, 64'h0);  at_neg(); chk("stream_0x12", o_data, 64'h12);
        step(); at_neg(); chk("stream_drained", o_valid, 1'b0);

        // reset with an entry held mid-stream
        step(); drive(1'b1, 64'h15); i_ready = 1'b0;
        step(); drive(1'b0, 64'h0); at_neg(); chk("pre_rst_valid", o_valid, 1'b1);
        do_reset();

        // backpressure
        step(); drive(1'b1, 64'hA); i_ready = 1'b0;
        step(); drive(1'b1, 64'hB); at_neg();
        chk("bp_first", o_data, 64'hA);
`ifdef PREG_SKID_EN
        chk("bp_ready_one", o_ready, 1'b1);
`else
        chk("bp_ready_one", o_ready, 1'b0);
`endif
        step(); at_neg();
        chk("bp_hold_a", o_data, 64'hA);
        chk("bp_ready_full", o_ready, 1'b0);
        chk("bp_cnt1", o_stall_cnt, 1);
        step(); i_ready = 1'b1; at_neg();
        chk("bp_hold_a2", o_data, 64'hA);
        chk("bp_cnt2", o_stall_cnt, 2);
        step(); drive(1'b0, 64'h0); at_neg();
        chk("bp_b_out", o_data, 64'hB);
        chk("bp_b_valid", o_valid, 1'b1);
        step(); at_neg();
        chk("bp_empty", o_valid, 1'b0);
        chk("bp_cnt_final", o_stall_cnt, 2);

        // flush with stage full, same-cycle input 0xC dropped
        do_reset();
        step(); drive(1'b1, 64'h21); i_ready = 1'b0;
        step(); drive(1'b1, 64'h22);
        step(); drive(1'b1, 64'hC); i_flush = 1'b1;
        step(); i_flush = 1'b0; drive(1'b1, 64'hD); at_neg();
        chk("flush_valid", o_valid, 1'b0);
        chk("flush_ctrl", o_ctrl, 0);
        chk("flush_data", o_data, FCD ? 64'h0 : 64'h21);
        chk("flush_ready", o_ready, 1'b1);
        step(); drive(1'b0, 64'h0); at_neg();
        chk("flush_next_accept", o_data, 64'hD);
        step(); i_ready = 1'b1;
        step(); step(); at_neg();
        chk("flush_drained", o_valid, 1'b0);

        // stall with downstream ready
        do_reset();
        step(); drive(1'b1, 64'h30); i_ready = 1'b1; i_stall = 1'b1;
        step(); drive(1'b0, 64'h0); at_neg();
        chk("stall_cnt0", o_stall_cnt, 0);
        chk("stall_data", o_data, 64'h30);
        step(); step(); step(); i_stall = 1'b0; at_neg();
        chk("stall_held", o_valid, 1'b1);
        chk("stall_held_data", o_data, 64'h30);
        chk("stall_cnt3", o_stall_cnt, 3);
        step(); at_neg();
        chk("stall_release", o_valid, 1'b0);
        chk("stall_cnt_keep", o_stall_cnt, 3);

        // saturation of the 4-bit counter
        do_reset();
        step(); drive(1'b1, 64'h40); i_ready = 1'b0;
        step(); drive(1'b0, 64'h0);
        for (int k = 0; k < 20; k++) begin
            step(); at_neg();
            if (k == 13) chk("sat_14", o_stall_cnt, 14);
            if (k == 14) chk("sat_15", o_stall_cnt, 15);
        end
        chk("sat_stop", o_stall_cnt, 15);
        chk("sat_data", o_data, 64'h40);

        // mixed traffic against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step();
            drive(($urandom_range(0, 3) != 0), {32'h5EED_0000, 32'($urandom)});
            i_ready = ($urandom_range(0, 3) != 0);
            i_stall = ($urandom_range(0, 4) == 0);
            i_flush = ($urandom_range(0, 16) == 0);
        end
        step(); i_flush = 1'b0; i_stall = 1'b0; i_ready = 1'b1; drive(1'b0, 64'h0);
        step(); step(); at_neg();

        chk("never_0xC", seen_c, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
